// File: rtl/div_int_pkg.sv
// Shared definitions for the sequential integer divider: FSM encoding,
// counter sizing helper and the divide-by-zero quotient constant.
package div_int_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DEF_DATA_WIDTH = 16;

   // Counter must hold the value DATA_WIDTH itself, hence the +1.
   function automatic int cnt_width(input int data_width);
      return $clog2(data_width + 1);
   endfunction

   localparam int CNT_WIDTH = cnt_width(DEF_DATA_WIDTH);

   // All-ones quotient reported for a zero divisor; sliced to DATA_WIDTH (<= 64).
   localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_int_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep or restore.
module div_int_step #(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] rem_in,
   input  logic                  bit_in,
   input  logic [DATA_WIDTH-1:0] dvs_mag,
   output logic [DATA_WIDTH-1:0] rem_out,
   output logic                  q_bit
);

   logic [DATA_WIDTH:0] shifted;
   logic [DATA_WIDTH:0] diff;

   // The extra MSB turns the borrow into a sign bit; rem_in < dvs_mag keeps
   // the kept result inside DATA_WIDTH bits.
   assign shifted = {rem_in, bit_in};
   assign diff    = shifted - {1'b0, dvs_mag};
   assign q_bit   = ~diff[DATA_WIDTH];
   assign rem_out = q_bit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/div_int_seq.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready on both sides.
// Define DIV_EARLY_TERM_EN to finish in one edge when |dividend| < |divisor|.
module div_int_seq
   import div_int_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  signed_op,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic                  div_by_zero
);

   localparam int CW = cnt_width(DATA_WIDTH);

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] rem_r, quo_r, dvs_mag;
   logic                  q_neg, r_neg, dbz_r;
   logic [DATA_WIDTH-1:0] dvd_abs, dvs_abs;
   logic [DATA_WIDTH-1:0] step_rem;
   logic                  step_q;
   logic                  accept, dvs_zero, early;

   assign dvd_abs  = (signed_op && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
   assign dvs_abs  = (signed_op && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;
   assign dvs_zero = (divisor == '0);
   assign accept   = in_valid & in_ready;

`ifdef DIV_EARLY_TERM_EN
   assign early = !dvs_zero && (dvd_abs < dvs_abs);
`else
   assign early = 1'b0;
`endif

   // quo_r doubles as the dividend shift register: its MSB feeds each step.
   div_int_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .rem_in  (rem_r),
      .bit_in  (quo_r[DATA_WIDTH-1]),
      .dvs_mag (dvs_mag),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path leaves
   // a variable unassigned, which would infer a latch.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = (dvs_zero || early) ? DONE : CALC;
         end
         CALC: if (cnt == CW'(1)) state_nxt = SIGN;
         SIGN: state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         rem_r   <= '0;
         quo_r   <= '0;
         dvs_mag <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         dbz_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               q_neg   <= signed_op & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
               r_neg   <= signed_op & dividend[DATA_WIDTH-1];
               dvs_mag <= dvs_abs;
               dbz_r   <= dvs_zero;
               if (dvs_zero) begin
                  quo_r <= DBZ_QUOTIENT[DATA_WIDTH-1:0];
                  rem_r <= dividend;
               end else if (early) begin
                  quo_r <= '0;
                  rem_r <= dividend;
               end else begin
                  quo_r <= dvd_abs;
                  rem_r <= '0;
                  cnt   <= CW'(DATA_WIDTH);
               end
            end
            CALC: begin
               rem_r <= step_rem;
               quo_r <= {quo_r[DATA_WIDTH-2:0], step_q};
               cnt   <= cnt - CW'(1);
            end
            SIGN: begin
               if (q_neg) quo_r <= -quo_r;
               if (r_neg) rem_r <= -rem_r;
            end
            default: ;
         endcase
      end
   end

   assign quotient    = quo_r;
   assign remainder   = rem_r;
   assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_div_int_seq.sv
// Self-checking bench for div_int_seq: directed vector table, hand-written
// backpressure/reset/early-termination sequences and a randomized model check.
module tb_div_int_seq;

   localparam int W = 16;
   localparam int FULL_LAT = W + 2;
   localparam int MAX_WAIT = 100;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         signed_op = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_cmp = 0;
   int n_bad = 0;

   div_int_seq #(.DATA_WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
   } vec_t;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic; SV / and % truncate toward zero,
   // so the remainder takes the dividend's sign.
   function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      int sa, sb;
      if (b == '0) begin
         q = '1; r = a; z = 1'b1;
      end else if (s) begin
         sa = $signed(a); sb = $signed(b);
         q = W'(sa / sb); r = W'(sa % sb); z = 1'b0;
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
   endfunction

   function automatic int magnitude(input logic s, input logic [W-1:0] v);
      int x;
      x = s ? int'($signed(v)) : int'(v);
      return (x < 0) ? -x : x;
   endfunction

   function automatic int exp_latency(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0) return 1;
`ifdef DIV_EARLY_TERM_EN
      if (magnitude(s, a) < magnitude(s, b)) return 1;
`endif
      return FULL_LAT;
   endfunction

   // Presents operands, counts edges from the accepting edge (inclusive) until
   // out_valid is seen, and returns sampled at posedge+1 with out_valid high.
   task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat);
      int n;
      signed_op = s; dividend = a; divisor = b; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < MAX_WAIT) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < MAX_WAIT) begin
         @(posedge clk); #1; lat++;
      end
      q = quotient; r = remainder; z = div_by_zero;
   endtask

   task automatic complete_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic op_and_check(input string tag, input logic s, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] eq,
                               input logic [W-1:0] er, input logic ez, input int elat);
      logic [W-1:0] q, r;
      logic z;
      int lat;
      run_op(s, a, b, q, r, z, lat);
      check({tag, " quotient"}, q, eq);
      check({tag, " remainder"}, r, er);
      check({tag, " div_by_zero"}, z, ez);
      check({tag, " latency"}, lat, elat);
      complete_result();
   endtask

   vec_t vecs[8];

   initial begin
      logic [W-1:0] q, r, mq, mr;
      logic z, mz, s;
      logic [W-1:0] a, b;
      int lat;

      vecs[0] = '{1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0};
      vecs[1] = '{1'b1, 16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0};
      vecs[2] = '{1'b1, 16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0};
      vecs[3] = '{1'b0, 16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1};
      vecs[4] = '{1'b1, 16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1};
      vecs[5] = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
      vecs[6] = '{1'b0, 16'hFFFF, 16'd255,  16'd257,  16'd0,    1'b0};
      vecs[7] = '{1'b1, 16'hFF9C, 16'hFFF9, 16'd14,   16'hFFFE, 1'b0};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset quotient", quotient, 0);
      check("reset remainder", remainder, 0);
      check("reset div_by_zero", div_by_zero, 0);

      for (int i = 0; i < 8; i++)
         op_and_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                      vecs[i].q, vecs[i].r, vecs[i].z,
                      exp_latency(vecs[i].s, vecs[i].a, vecs[i].b));

      // Backpressure: result must hold while out_ready is low.
      out_ready = 1'b0;
      run_op(1'b0, 16'd50, 16'd5, q, r, z, lat);
      check("bp latency", lat, FULL_LAT);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp out_valid held", out_valid, 1);
         check("bp quotient held", quotient, 10);
         check("bp remainder held", remainder, 0);
         check("bp in_ready low", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp release in_ready", in_ready, 1);
      check("bp release out_valid", out_valid, 0);
      op_and_check("b2b 9/4", 1'b0, 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, FULL_LAT);

      // Reset during the 8th CALC cycle aborts immediately.
      signed_op = 1'b0; dividend = 16'd1000; divisor = 16'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort out_valid", out_valid, 0);
      check("abort in_ready", in_ready, 1);
      check("abort quotient", quotient, 0);
      check("abort remainder", remainder, 0);
      @(posedge clk); #1 rst = 1'b0;
      op_and_check("after abort", 1'b0, 16'hFFFF, 16'd255, 16'd257, 16'd0, 1'b0, FULL_LAT);

      op_and_check("small 3/200", 1'b0, 16'd3, 16'd200, 16'd0, 16'd3, 1'b0,
                   exp_latency(1'b0, 16'd3, 16'd200));

      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom);
         a = W'($urandom);
         case ($urandom_range(0, 5))
            0:       b = '0;
            1:       b = 16'hFFFF;
            2:       b = W'($urandom_range(1, 15));
            default: b = W'($urandom);
         endcase
         if ($urandom_range(0, 9) == 0) a = 16'h8000;
         model(s, a, b, mq, mr, mz);
         op_and_check($sformatf("rnd%0d", i), s, a, b, mq, mr, mz, exp_latency(s, a, b));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/div_int_seq.md
Name: div_int_seq

Overview:
Multi-cycle integer divider. It is the inverse-direction companion to the mul_int multiplier datapath in the arithmetic-unit library.
- Radix-2 restoring algorithm, one quotient bit per clock.
- Signed and unsigned operation.
- Valid/ready handshake on both the operand side and the result side.
- Sits beside the multiplier in the integer execute stage; accepts one operation at a time.

Parameters:
DATA_WIDTH, 16, operand/result width in bits (>=4)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands (high only in IDLE)
signed_op  input  1  1 = two's-complement divide, 0 = unsigned
dividend  input  DATA_WIDTH  numerator
divisor  input  DATA_WIDTH  denominator
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  DATA_WIDTH  quotient
remainder  output  DATA_WIDTH  remainder
div_by_zero  output  1  divisor was zero for the presented result

Behaviour:
- Clock and reset (already decided): single clock clk; reset rst is asynchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- Reset asserted mid-operation aborts the operation immediately. No partial result is ever presented.
- FSM states: IDLE, CALC, SIGN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch magnitudes |dividend| and |divisor| (two's-complement abs only when signed_op=1; abs taken as unsigned DATA_WIDTH bits).
  - Latch the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Next state: DONE if divisor==0, else CALC with counter=DATA_WIDTH.
- CALC:
  - Each edge: shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude. If non-negative, keep the difference and set the quotient bit to 1; else restore and set it to 0.
  - Counter decrements; at counter==1 go to SIGN.
- SIGN: negate the quotient if its sign bit is set; negate the remainder if its sign bit is set (signed_op only). Next state DONE.
- DONE:
  - out_valid=1; outputs are held stable while out_ready=0.
  - On out_valid&out_ready: go to IDLE, so in_ready=1 in the following cycle.
- Latency: out_valid rises exactly DATA_WIDTH+2 edges after the accepting edge. No throughput overlap: a new accept is possible only after the result handshake.
- Divide by zero: out_valid one edge after accept; quotient=all ones, remainder=dividend (original value), div_by_zero=1.
- Signed overflow (most-negative / -1): quotient=most-negative, remainder=0, div_by_zero=0. This falls out of the unsigned-abs datapath; no special case.
- Remainder sign always follows the dividend; |remainder| < |divisor|.
- in_valid while not in IDLE is ignored; operands must be held by the producer until accepted.

Optional Feature:
DIV_EARLY_TERM_EN
- Defined: in IDLE, if divisor!=0 and |dividend| < |divisor| (unsigned compare of magnitudes), skip CALC/SIGN. Go to DONE on the next edge with quotient=0 and remainder=dividend (original value), so out_valid arrives 1 edge after accept.
- Undefined: every nonzero-divisor operation takes the full DATA_WIDTH+2 latency.
- Results are identical either way; only latency differs.

Decomposition:
- Package div_int_pkg holds:
  - state encoding constants (IDLE, CALC, SIGN, DONE);
  - CNT_WIDTH = clog2(DATA_WIDTH+1);
  - the divide-by-zero quotient constant (all ones).
- One combinational sub-module, div_int_step: a single restoring step. Inputs are partial remainder, next dividend bit and divisor magnitude; outputs are the new partial remainder and the quotient bit. It is instantiated once in the top-level FSM.

Test Plan:
- Unsigned 100/7 (DATA_WIDTH=16) -> quotient=14, remainder=2, div_by_zero=0, out_valid exactly 18 edges after accept.
- Signed 0xFF9C(-100)/7 -> quotient=0xFFF2(-14), remainder=0xFFFE(-2); signed 100/0xFFF9(-7) -> quotient=0xFFF2, remainder=0x0002.
- 1234/0 (both signed_op values) -> quotient=0xFFFF, remainder=1234, div_by_zero=1, out_valid one edge after accept.
- Signed 0x8000/0xFFFF -> quotient=0x8000, remainder=0x0000, div_by_zero=0.
- Backpressure: hold out_ready=0 for 5 cycles on result of 50/5 -> quotient=10 and remainder=0 stable, in_ready=0 throughout; release -> in_ready=1 the next cycle; back-to-back second op 9/4 -> quotient=2, remainder=1.
- Assert rst for 1 cycle at the 8th CALC cycle -> out_valid=0, in_ready=1, outputs 0 immediately; next op 65535/255 unsigned -> quotient=257, remainder=0. With DIV_EARLY_TERM_EN, 3/200 -> quotient=0, remainder=3 after 1 edge.
